// File: rtl/imem_pkg.sv
// Shared types for the instruction-ROM port arbiter.
// States, access sizes, port ids and size helpers.
package imem_pkg;

    localparam int ROM_ADDR_W = 16;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_e;

    function automatic size_e decode_size(input logic [1:0] s);
        case (s)
            2'd0:    return SZ_B;
            2'd1:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic [2:0] size_beats(input size_e s);
        case (s)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Collects serially read ROM bytes into lanes and
// presents them packed and size/sign extended.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clr,
    input  logic              i_cap,
    input  logic [1:0]        i_lane,
    input  logic [7:0]        i_byte,
    input  size_e             i_size,
    input  logic              i_unsigned,
    output logic [DATA_W-1:0] o_data
);

    logic [3:0][7:0] r_lanes;
    logic [3:0][7:0] w_lanes;

    // Current lanes with the byte arriving this cycle merged in,
    // so the final byte is visible the same cycle it is captured.
    always_comb begin
        w_lanes = r_lanes;
        if (i_cap) begin
            w_lanes[i_lane] = i_byte;
        end
    end

    // Lane storage, cleared at the start of each transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lanes <= '0;
        end else if (i_clr) begin
            r_lanes <= '0;
        end else if (i_cap) begin
            r_lanes <= w_lanes;
        end
    end

    // Byte/half extension; words pass through untouched.
    always_comb begin
        o_data = w_lanes;
        case (i_size)
            SZ_B: begin
                if (i_unsigned) begin
                    o_data = {24'd0, w_lanes[0]};
                end else begin
                    o_data = {{24{w_lanes[0][7]}}, w_lanes[0]};
                end
            end
            SZ_H: begin
                if (i_unsigned) begin
                    o_data = {16'd0, w_lanes[1], w_lanes[0]};
                end else begin
                    o_data = {{16{w_lanes[1][7]}}, w_lanes[1], w_lanes[0]};
                end
            end
            default: o_data = w_lanes;
        endcase
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Round-robin sharing of the byte-wide program ROM
// between instruction fetch and constant loads.
module imem_port_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ROM_ADDR_WIDTH = ROM_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic                      if_valid,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_err,
    input  logic                      ld_req,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [1:0]                ld_size,
    input  logic                      ld_unsigned,
    output logic                      ld_valid,
    output logic [DATA_WIDTH-1:0]     ld_rdata,
    output logic                      ld_err,
    output logic                      rom_en,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]                rom_rdata
);

    localparam logic [ADDR_WIDTH:0] ROM_LAST =
        (ADDR_WIDTH+1)'((64'd1 << ROM_ADDR_WIDTH) - 64'd1);

    state_e                    r_state;
    port_e                     r_port;
    port_e                     r_last;
    size_e                     r_size;
    logic                      r_uns;
    logic [2:0]                r_nb;
    logic [2:0]                r_beat;
    logic                      r_rom_en;
    logic [ROM_ADDR_WIDTH-1:0] r_rom_addr;
    logic                      r_if_valid;
    logic [DATA_WIDTH-1:0]     r_if_rdata;
    logic                      r_if_err;
    logic                      r_ld_valid;
    logic [DATA_WIDTH-1:0]     r_ld_rdata;
    logic                      r_ld_err;

    logic                  w_any;
    logic                  w_pick_ld;
    size_e                 w_size;
    logic [2:0]            w_n;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [ADDR_WIDTH:0]   w_end;
    logic                  w_err;
    logic                  w_grant;
    logic                  w_cap;
    logic [1:0]            w_lane;
    logic [DATA_W-1:0]     w_packed;

    // Grant selection: a lone request wins; on a tie the port
    // not served last wins. Range is checked on the last byte.
    always_comb begin
        w_any     = if_req | ld_req;
        w_pick_ld = ld_req & (~if_req | (r_last == PORT_IF));
        w_size    = w_pick_ld ? decode_size(ld_size) : SZ_W;
        w_base    = w_pick_ld ? ld_addr : if_addr;
        w_n       = size_beats(w_size);
        w_end     = {1'b0, w_base}
                  + {{(ADDR_WIDTH-2){1'b0}}, w_n}
                  - {{ADDR_WIDTH{1'b0}}, 1'b1};
        w_err     = (w_end > ROM_LAST);
        w_grant   = (r_state == S_IDLE) & w_any;
    end

    // Byte capture: data lags rom_en by one cycle, so lane k-1
    // lands during beat k and the last lane during DRAIN.
    always_comb begin
        w_cap  = 1'b0;
        w_lane = r_beat[1:0] - 2'd1;
        if (r_state == S_DRAIN) begin
            w_cap  = 1'b1;
            w_lane = r_nb[1:0] - 2'd1;
        end else if (r_state == S_ISSUE && r_beat != 3'd0) begin
            w_cap  = 1'b1;
        end
    end

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (w_grant & ~w_err),
        .i_cap      (w_cap),
        .i_lane     (w_lane),
        .i_byte     (rom_rdata),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_packed)
    );

    // Transaction FSM with registered ROM strobe and responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_port     <= PORT_IF;
            r_last     <= PORT_LD;
            r_size     <= SZ_W;
            r_uns      <= 1'b0;
            r_nb       <= 3'd0;
            r_beat     <= 3'd0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_if_valid <= 1'b0;
            r_if_rdata <= '0;
            r_if_err   <= 1'b0;
            r_ld_valid <= 1'b0;
            r_ld_rdata <= '0;
            r_ld_err   <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_ld_valid <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port <= w_pick_ld ? PORT_LD : PORT_IF;
                        r_size <= w_size;
                        r_uns  <= w_pick_ld & ld_unsigned;
                        r_nb   <= w_n;
                        r_beat <= 3'd0;
                        if (w_err) begin
                            r_state <= S_RESP;
                            if (w_pick_ld) begin
                                r_ld_valid <= 1'b1;
                                r_ld_rdata <= '0;
                                r_ld_err   <= 1'b1;
                            end else begin
                                r_if_valid <= 1'b1;
                                r_if_rdata <= '0;
                                r_if_err   <= 1'b1;
                            end
                        end else begin
                            r_state    <= S_ISSUE;
                            r_rom_en   <= 1'b1;
                            r_rom_addr <= w_base[ROM_ADDR_WIDTH-1:0];
                        end
                    end
                end
                S_ISSUE: begin
                    r_beat <= r_beat + 3'd1;
                    if (r_beat == r_nb - 3'd1) begin
                        r_rom_en <= 1'b0;
                        r_state  <= S_DRAIN;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_RESP;
                    if (r_port == PORT_LD) begin
                        r_ld_valid <= 1'b1;
                        r_ld_rdata <= w_packed;
                        r_ld_err   <= 1'b0;
                    end else begin
                        r_if_valid <= 1'b1;
                        r_if_rdata <= w_packed;
                        r_if_err   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_last  <= r_port;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign if_valid = r_if_valid;
    assign if_rdata = r_if_rdata;
    assign if_err   = r_if_err;
    assign ld_valid = r_ld_valid;
    assign ld_rdata = r_ld_rdata;
    assign ld_err   = r_ld_err;
    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a
// synchronous byte ROM model.
module tb_imem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [1:0]  ld_size = '0;
    logic        ld_unsigned = 1'b0;
    logic        ld_valid;
    logic [31:0] ld_rdata;
    logic        ld_err;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [7:0]  rom_rdata = '0;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:65535];

    imem_port_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_valid    (if_valid),
        .if_rdata    (if_rdata),
        .if_err      (if_err),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_size     (ld_size),
        .ld_unsigned (ld_unsigned),
        .ld_valid    (ld_valid),
        .ld_rdata    (ld_rdata),
        .ld_err      (ld_err),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_rdata   (rom_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_rdata <= mem[rom_addr];
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0000] = 8'h13;
        mem[16'h0001] = 8'h05;
        mem[16'h0002] = 8'h00;
        mem[16'h0003] = 8'h00;
        mem[16'h0010] = 8'h80;
        mem[16'h0011] = 8'hFF;
        mem[16'h0012] = 8'h34;
        mem[16'h0013] = 8'h12;
        mem[16'hFFFE] = 8'hAA;
        mem[16'hFFFF] = 8'hBB;
    end

    // One transaction; cycle 0 is the cycle the request is first
    // presented. Returns the valid cycle (-1 on timeout).
    task automatic do_xact(
        input  bit          is_ld,
        input  logic [31:0] addr,
        input  logic [1:0]  size,
        input  logic        uns,
        output int          cyc,
        output logic [31:0] data,
        output logic        err,
        output int          nen
    );
        @(negedge clk);
        if (is_ld) begin
            ld_req = 1'b1;
            ld_addr = addr;
            ld_size = size;
            ld_unsigned = uns;
        end else begin
            if_req = 1'b1;
            if_addr = addr;
        end
        cyc = -1;
        nen = 0;
        data = 'x;
        err = 1'bx;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (rom_en) nen++;
            if (is_ld ? ld_valid : if_valid) begin
                cyc = c;
                data = is_ld ? ld_rdata : if_rdata;
                err = is_ld ? ld_err : if_err;
                break;
            end
        end
        ld_req = 1'b0;
        if_req = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_valid, if_err, ld_valid, ld_err, rom_en} !== 5'b0 ||
            if_rdata !== 32'h0 || ld_rdata !== 32'h0 ||
            rom_addr !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs iv=%b ie=%b lv=%b le=%b en=%b ir=%h lr=%h ra=%h",
                     if_valid, if_err, ld_valid, ld_err, rom_en,
                     if_rdata, ld_rdata, rom_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        int          vc [4];
        int          vp [4];
        logic [31:0] vd [4];
        int          ec [4];
        int          ep [4];
        logic [31:0] ed [4];
        int          n;
        ec = '{6, 10, 17, 21};
        ep = '{0, 1, 0, 1};
        ed = '{32'h0000_0513, 32'h0000_0080, 32'h0000_0513, 32'h0000_0080};
        for (int i = 0; i < 4; i++) begin
            vc[i] = -1;
            vp[i] = -1;
            vd[i] = 'x;
        end
        n = 0;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h0;
        ld_req = 1'b1;
        ld_addr = 32'h10;
        ld_size = 2'd0;
        ld_unsigned = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (if_valid || ld_valid) begin
                vc[n] = c;
                vp[n] = ld_valid ? 1 : 0;
                vd[n] = ld_valid ? ld_rdata : if_rdata;
                n++;
            end
            if (n == 4) break;
        end
        if_req = 1'b0;
        ld_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vc[i] !== ec[i] || vp[i] !== ep[i] || vd[i] !== ed[i]) begin
                failures++;
                $display("FAIL arb_grant%0d got cyc=%0d port=%0d data=%h want cyc=%0d port=%0d data=%h",
                         i, vc[i], vp[i], vd[i], ec[i], ep[i], ed[i]);
            end
        end
    endtask

    task automatic test_fetch;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                checks++;
                if (rom_en !== 1'b1 || rom_addr !== 16'(c - 1)) begin
                    failures++;
                    $display("FAIL fetch_rom_beat%0d got en=%b addr=%h want en=1 addr=%h",
                             c, rom_en, rom_addr, 16'(c - 1));
                end
            end else if (c == 5) begin
                checks++;
                if (rom_en !== 1'b0 || rom_addr !== 16'h3 || if_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_drain got en=%b addr=%h v=%b want en=0 addr=0003 v=0",
                             rom_en, rom_addr, if_valid);
                end
            end else begin
                checks++;
                if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0513 || if_err !== 1'b0) begin
                    failures++;
                    $display("FAIL fetch_resp got v=%b data=%h err=%b want v=1 data=00000513 err=0",
                             if_valid, if_rdata, if_err);
                end
            end
        end
        if_req = 1'b0;
        @(negedge clk);
        checks++;
        if (if_valid !== 1'b0 || if_rdata !== 32'h0000_0513) begin
            failures++;
            $display("FAIL fetch_hold got v=%b data=%h want v=0 data=00000513",
                     if_valid, if_rdata);
        end
    endtask

    task automatic test_loads;
        logic [31:0] va [6];
        logic [1:0]  vs [6];
        logic        vu [6];
        int          ecyc [6];
        logic [31:0] edat [6];
        int          cyc;
        logic [31:0] d;
        logic        e;
        int          nen;
        va   = '{32'h10, 32'h10, 32'h11, 32'h10, 32'h10, 32'h10};
        vs   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
        vu   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        ecyc = '{3, 3, 4, 4, 6, 6};
        edat = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_34FF,
                 32'h0000_FF80, 32'h1234_FF80, 32'h1234_FF80};
        for (int i = 0; i < 6; i++) begin
            do_xact(1'b1, va[i], vs[i], vu[i], cyc, d, e, nen);
            checks++;
            if (cyc !== ecyc[i] || d !== edat[i] || e !== 1'b0 ||
                nen !== ecyc[i] - 2) begin
                failures++;
                $display("FAIL load%0d got cyc=%0d data=%h err=%b beats=%0d want cyc=%0d data=%h err=0 beats=%0d",
                         i, cyc, d, e, nen, ecyc[i], edat[i], ecyc[i] - 2);
            end
        end
    endtask

    task automatic test_range;
        int          cyc;
        logic [31:0] d;
        logic        e;
        int          nen;
        do_xact(1'b1, 32'hFFFE, 2'd2, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 1 || d !== 32'h0 || e !== 1'b1 || nen !== 0) begin
            failures++;
            $display("FAIL range_ld_word got cyc=%0d data=%h err=%b beats=%0d want 1 00000000 1 0",
                     cyc, d, e, nen);
        end
        @(negedge clk);
        checks++;
        if (ld_valid !== 1'b0 || ld_err !== 1'b1) begin
            failures++;
            $display("FAIL range_err_hold got v=%b err=%b want v=0 err=1", ld_valid, ld_err);
        end
        do_xact(1'b1, 32'hFFFE, 2'd1, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 4 || d !== 32'hFFFF_BBAA || e !== 1'b0 || nen !== 2) begin
            failures++;
            $display("FAIL range_ld_half got cyc=%0d data=%h err=%b beats=%0d want 4 ffffbbaa 0 2",
                     cyc, d, e, nen);
        end
        do_xact(1'b1, 32'hFFFF, 2'd0, 1'b1, cyc, d, e, nen);
        checks++;
        if (cyc !== 3 || d !== 32'h0000_00BB || e !== 1'b0) begin
            failures++;
            $display("FAIL range_ld_lastbyte got cyc=%0d data=%h err=%b want 3 000000bb 0",
                     cyc, d, e);
        end
        do_xact(1'b1, 32'h0001_0000, 2'd0, 1'b1, cyc, d, e, nen);
        checks++;
        if (cyc !== 1 || d !== 32'h0 || e !== 1'b1 || nen !== 0) begin
            failures++;
            $display("FAIL range_ld_upper got cyc=%0d data=%h err=%b beats=%0d want 1 00000000 1 0",
                     cyc, d, e, nen);
        end
        do_xact(1'b0, 32'hFFFC, 2'd0, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 6 || d !== 32'hBBAA_0000 || e !== 1'b0 || nen !== 4) begin
            failures++;
            $display("FAIL range_if_top got cyc=%0d data=%h err=%b beats=%0d want 6 bbaa0000 0 4",
                     cyc, d, e, nen);
        end
        do_xact(1'b0, 32'hFFFD, 2'd0, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 1 || d !== 32'h0 || e !== 1'b1 || nen !== 0) begin
            failures++;
            $display("FAIL range_if_over got cyc=%0d data=%h err=%b beats=%0d want 1 00000000 1 0",
                     cyc, d, e, nen);
        end
    endtask

    task automatic test_reset_mid;
        int          cyc;
        logic [31:0] d;
        logic        e;
        int          nen;
        int          stray;
        do_xact(1'b0, 32'h10, 2'd0, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 6 || d !== 32'h1234_FF80) begin
            failures++;
            $display("FAIL premid_fetch got cyc=%0d data=%h want 6 1234ff80", cyc, d);
        end
        @(negedge clk);
        if_req = 1'b1;
        if_addr = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (rom_en !== 1'b0 || rom_addr !== 16'h0 || if_valid !== 1'b0 ||
            if_rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_out got en=%b addr=%h v=%b data=%h want 0 0000 0 00000000",
                     rom_en, rom_addr, if_valid, if_rdata);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_valid || ld_valid || rom_en) stray++;
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL mid_reset_quiet got %0d active cycles want 0", stray);
        end
        do_xact(1'b0, 32'h0, 2'd0, 1'b0, cyc, d, e, nen);
        checks++;
        if (cyc !== 6 || d !== 32'h0000_0513 || e !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_fetch got cyc=%0d data=%h err=%b want 6 00000513 0",
                     cyc, d, e);
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_fetch();
        test_loads();
        test_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
